// File: rtl/sram_port_arbiter.sv
// Frame SRAM sequencer: captures decoder YUV bytes through a small FIFO into an
// auto-incrementing frame buffer and serves host reads in slots video leaves free.
module sram_port_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              llc,
  input  logic              rst,
  input  logic              href,
  input  logic              vref,
  input  logic [DATA_W-1:0] yuv,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] sram_adr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_we_n,
  output logic              sram_rd_n,
  output logic              ovf,
  output logic              frame_start
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, VW1, VW2, HR1, HR2} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_idx, wr_idx;
  logic [PTR_W:0]    count;
  logic              fifo_empty, fifo_full;
  logic              push_req, push, pop, flush, rise;
  logic              phase, vref_q;
  logic [ADDR_W-1:0] wr_ptr, adr_next;
  logic [DATA_W-1:0] dout_next;
  logic              oe_next, we_n_next, rd_n_next;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign push_req   = href & vref & phase;
  assign push       = push_req & ~fifo_full;
  assign flush      = ~vref;
  // A flush during VW1 can leave VW2 with nothing to pop; guard the count.
  assign pop        = (state == VW2) & ~fifo_empty;
  assign rise       = vref & ~vref_q;

  always_ff @(posedge llc or posedge rst) begin
    if (rst) begin
      vref_q      <= 1'b0;
      frame_start <= 1'b0;
      phase       <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      vref_q      <= vref;
      frame_start <= rise;
      phase       <= (href & vref) ? ~phase : 1'b0;
      if (push_req & fifo_full)
        ovf <= 1'b1;
      else if (rise)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge llc or posedge rst) begin
    if (rst) begin
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < unsigned'(FIFO_DEPTH); i++)
        fifo_mem[i] <= '0;
    end else if (flush) begin
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_idx] <= yuv;
        wr_idx           <= wr_idx + PTR_W'(1);
      end
      if (pop)
        rd_idx <= rd_idx + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge llc or posedge rst) begin
    if (rst)
      wr_ptr <= '0;
    else if (flush)
      wr_ptr <= '0;
    else if (state == VW2)
      wr_ptr <= wr_ptr + ADDR_W'(1);
  end

  // Pin values are computed for the state being entered and registered, so the
  // SRAM sees stable, glitch-free address and strobes for each state.
  always_comb begin
    state_next = state;
    adr_next   = sram_adr;
    dout_next  = sram_dout;
    oe_next    = 1'b0;
    we_n_next  = 1'b1;
    rd_n_next  = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = VW1;
          adr_next   = wr_ptr;
          dout_next  = fifo_mem[rd_idx];
          oe_next    = 1'b1;
        end else if (host_req && !host_ack) begin
          state_next = HR1;
          adr_next   = host_addr;
          rd_n_next  = 1'b0;
        end
      end
      VW1: begin
        state_next = VW2;
        oe_next    = 1'b1;
        we_n_next  = 1'b0;
      end
      VW2: state_next = IDLE;
      HR1: begin
        state_next = HR2;
        rd_n_next  = 1'b0;
      end
      HR2:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge llc or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sram_adr   <= '0;
      sram_dout  <= '0;
      sram_oe    <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_rd_n  <= 1'b1;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      state     <= state_next;
      sram_adr  <= adr_next;
      sram_dout <= dout_next;
      sram_oe   <= oe_next;
      sram_we_n <= we_n_next;
      sram_rd_n <= rd_n_next;
      host_ack  <= (state == HR2);
      if (state == HR2)
        host_rdata <= sram_din;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: a queue model of captured bytes and a
// frame address counter predict every SRAM write; a reference memory predicts host reads.
module tb_sram_port_arbiter;

  localparam int AW  = 19;
  localparam int SAW = 3;

  logic          llc = 1'b0;
  logic          rst;
  logic          href, vref, host_req;
  logic [7:0]    yuv;
  logic [AW-1:0] host_addr;
  logic          host_ack, sram_oe, sram_we_n, sram_rd_n, ovf, frame_start;
  logic [7:0]    host_rdata, sram_dout, sram_din;
  logic [AW-1:0] sram_adr;

  logic           s_host_ack, s_oe, s_we_n, s_rd_n, s_ovf, s_fs;
  logic [7:0]     s_host_rdata, s_dout, s_din;
  logic [SAW-1:0] s_adr, s_host_addr;

  bit [7:0] mem     [1<<AW];
  bit [7:0] ref_mem [1<<AW];

  logic [7:0]    exp_q [$];
  logic [AW-1:0] m_wadr = '0;
  logic          m_phase = 1'b0;
  logic [7:0]    e;
  logic [AW-1:0] prev_adr = '0;
  logic          prev_oe = 1'b0, prev_we_n = 1'b1;
  bit            sb_on = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 llc = ~llc;

  assign sram_din    = sram_rd_n ? 8'h00 : mem[sram_adr];
  assign s_din       = 8'h00;
  assign s_host_addr = host_addr[SAW-1:0];

  sram_port_arbiter dut (
    .llc(llc), .rst(rst), .href(href), .vref(vref), .yuv(yuv),
    .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack),
    .host_rdata(host_rdata), .sram_adr(sram_adr), .sram_dout(sram_dout),
    .sram_oe(sram_oe), .sram_din(sram_din), .sram_we_n(sram_we_n),
    .sram_rd_n(sram_rd_n), .ovf(ovf), .frame_start(frame_start)
  );

  // Narrow-address twin driven identically; exercises write-pointer wrap quickly.
  sram_port_arbiter #(.ADDR_W(SAW)) dut_small (
    .llc(llc), .rst(rst), .href(href), .vref(vref), .yuv(yuv),
    .host_req(host_req), .host_addr(s_host_addr), .host_ack(s_host_ack),
    .host_rdata(s_host_rdata), .sram_adr(s_adr), .sram_dout(s_dout),
    .sram_oe(s_oe), .sram_din(s_din), .sram_we_n(s_we_n),
    .sram_rd_n(s_rd_n), .ovf(s_ovf), .frame_start(s_fs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge llc) begin
    if (rst) mem[5] <= 8'hA5;
    else if (!sram_we_n) mem[sram_adr] <= sram_dout;
  end

  always @(posedge llc) begin
    #1;
    if (rst) begin
      exp_q.delete();
      m_wadr     = '0;
      m_phase    = 1'b0;
      ref_mem[5] = 8'hA5;
    end else begin
      check("pin_exclusive", (!sram_rd_n && (sram_oe || !sram_we_n)), 0);
      check("lockstep", {s_we_n, s_rd_n, s_oe, s_host_ack, s_ovf},
                        {sram_we_n, sram_rd_n, sram_oe, host_ack, ovf});
      if (!sram_rd_n) check("rd_adr", sram_adr, host_addr);
      if (!sram_we_n) begin
        check("wr_setup", {prev_oe, prev_we_n, prev_adr}, {2'b11, sram_adr});
        check("we_oe", sram_oe, 1);
        if (sb_on) begin
          check("wr_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_adr", sram_adr, m_wadr);
            check("wr_data", sram_dout, e);
            check("small_wr", {s_adr, s_dout}, {m_wadr[SAW-1:0], e});
            ref_mem[m_wadr] = e;
            m_wadr = m_wadr + 1'b1;
          end
        end
      end
      if (href && vref) begin
        if (m_phase && sb_on) exp_q.push_back(yuv);
        m_phase = ~m_phase;
      end else begin
        m_phase = 1'b0;
      end
      if (!sb_on) exp_q.delete();
      if (!vref) begin
        exp_q.delete();
        m_wadr = '0;
      end
    end
    prev_adr  = sram_adr;
    prev_oe   = sram_oe;
    prev_we_n = sram_we_n;
  end

  task automatic drive_line(input int len, input bit ramp, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      @(negedge llc);
      href = 1'b1;
      yuv  = ramp ? 8'(base + k) : 8'($urandom);
    end
    @(negedge llc);
    href = 1'b0;
    yuv  = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(posedge llc); #2;
      n++;
    end while (!(exp_q.size() == 0 && sram_we_n && sram_rd_n && !sram_oe) && n < 200);
    check("drain", n < 200, 1);
  endtask

  task automatic host_read(input logic [AW-1:0] a, input bit exact, input bit during_line);
    int n = 0;
    @(negedge llc);
    host_req  = 1'b1;
    host_addr = a;
    do begin
      @(posedge llc); #2;
      n++;
    end while (!host_ack && n < 300);
    check("host_ack_seen", host_ack, 1);
    if (exact) check("host_latency", n, 3);
    check("host_rdata", host_rdata, ref_mem[a]);
    if (during_line) begin
      check("host_after_href", href, 0);
      check("host_fifo_drained", exp_q.size(), 0);
    end
    // host still holds req across the next edge; no second read may start
    @(posedge llc); #2;
    check("host_ack_pulse", host_ack, 0);
    check("host_single_read", sram_rd_n, 1);
    @(negedge llc);
    host_req = 1'b0;
    @(posedge llc); #2;
    check("host_idle", {host_ack, sram_rd_n}, 2'b01);
  endtask

  task automatic vsync(input logic ovf_exp);
    @(negedge llc);
    vref = 1'b0;
    repeat (4) @(negedge llc);
    check("fs_low", frame_start, 0);
    check("ovf_before_rise", ovf, ovf_exp);
    vref = 1'b1;
    @(posedge llc); #2;
    check("frame_start", {frame_start, s_fs}, 2'b11);
    check("ovf_after_rise", ovf, 0);
    @(posedge llc); #2;
    check("frame_start_pulse", frame_start, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int n;
    logic [AW-1:0] a;
    rst = 1'b1; href = 1'b0; vref = 1'b0; yuv = '0;
    host_req = 1'b0; host_addr = '0;
    repeat (3) @(negedge llc);
    check("rst_strobes", {sram_we_n, sram_rd_n, sram_oe}, 3'b110);
    check("rst_host", {host_ack, host_rdata}, 0);
    check("rst_flags", {ovf, frame_start}, 0);
    check("rst_adr", sram_adr, 0);
    rst = 1'b0;

    vsync(1'b0);

    // host read of a preloaded location before any capture
    host_read(19'h00005, 1'b1, 1'b0);
    check("host_a5", host_rdata, 8'hA5);

    // 16-cycle ramp line: odd bytes land at 0..7
    drive_line(16, 1'b1, 8'h10);
    wait_drain();
    for (int i = 0; i < 8; i++) check("ramp_mem", mem[i], 8'(8'h11 + 2 * i));
    // two more bytes push the narrow twin through 7 -> 0
    drive_line(4, 1'b1, 8'h40);
    wait_drain();
    check("mem8", {mem[8], mem[9]}, 16'h4143);

    // host request raised mid-line waits for the line to drain
    fork
      drive_line(16, 1'b0, 8'h00);
      begin
        repeat (4) @(negedge llc);
        host_read(19'h00003, 1'b0, 1'b1);
      end
    join
    wait_drain();

    // asynchronous reset in the middle of a write strobe
    fork
      drive_line(12, 1'b0, 8'h00);
      begin
        n = 0;
        do begin
          @(posedge llc); #2;
          n++;
        end while (sram_we_n && n < 50);
        check("saw_vw2", sram_we_n, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_strobes", {sram_we_n, sram_rd_n, sram_oe}, 3'b110);
        @(posedge llc); #2;
        @(negedge llc);
        rst = 1'b0;
      end
    join
    wait_drain();

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      vsync(1'b0);
      for (int l = 0; l < int'($urandom_range(3, 5)); l++) begin
        drive_line(int'($urandom_range(2, 16)), 1'b0, 8'h00);
        wait_drain();
        check("ovf_clear", ovf, 0);
        if ($urandom_range(0, 1) == 1) begin
          if (m_wadr > 0 && $urandom_range(0, 1) == 1)
            a = AW'($urandom_range(0, int'(m_wadr) - 1));
          else
            a = 19'h40000 | AW'($urandom_range(0, 32'h3FFFF));
          host_read(a, 1'b1, 1'b0);
        end
        repeat ($urandom_range(1, 4)) @(negedge llc);
      end
    end

    // host slot taken as the line starts, then a line too long for the FIFO
    wait_drain();
    @(negedge llc);
    sb_on = 1'b0;
    fork
      host_read(19'h40000, 1'b1, 1'b0);
      drive_line(40, 1'b0, 8'h00);
    join
    check("ovf_set", {ovf, s_ovf}, 2'b11);
    vsync(1'b1);
    @(negedge llc);
    sb_on = 1'b1;
    drive_line(6, 1'b0, 8'h00);
    wait_drain();
    check("ovf_new_frame", ovf, 0);
    check("small_rdata", s_host_rdata, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
